// File: rtl/intdiv_ctrl_if.sv
// intdiv_ctrl_if: request, datapath-status and control-strobe bundle of the SD2 divider sequencer.
interface intdiv_ctrl_if #(parameter int CW = 5);
    logic          start;
    logic          xmsb;
    logic          ymsb;
    logic          y_zero;
    logic          padj_in;
    logic          seladj_in;
    logic          busy;
    logic          load_en;
    logic          iter_en;
    logic [CW-1:0] step;
    logic          adj_en;
    logic          padj;
    logic          seladj;
    logic          xmsb_q;
    logic          ymsb_q;
    logic          done;
    logic          err;
    modport master (
        output start, xmsb, ymsb, y_zero, padj_in, seladj_in,
        input  busy, load_en, iter_en, step, adj_en, padj, seladj, xmsb_q, ymsb_q, done, err
    );
    modport slave (
        input  start, xmsb, ymsb, y_zero, padj_in, seladj_in,
        output busy, load_en, iter_en, step, adj_en, padj, seladj, xmsb_q, ymsb_q, done, err
    );
endinterface

// File: rtl/intdiv_ctrl.sv
// intdiv_ctrl: sequencer for an N-digit SD2 integer divider (load, N iterations, adjust, done).
module intdiv_ctrl #(
    parameter int N  = 16,
    parameter int CW = 5
) (
    input logic         clk,
    input logic         rst,
    intdiv_ctrl_if.slave d
);
    typedef enum logic [2:0] {IDLE, LOAD, ITER, ADJ, DONE} state_t;
    state_t        state, nxt;
    logic [CW-1:0] step_q;
    logic          padj_q, seladj_q, err_q, xq, yq;
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = d.start ? LOAD : IDLE;
            LOAD:    nxt = d.y_zero ? DONE : ITER;
            ITER:    nxt = (step_q == '0) ? ADJ : ITER;
            ADJ:     nxt = DONE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q   <= '0;
            padj_q   <= 1'b0;
            seladj_q <= 1'b0;
            err_q    <= 1'b0;
            xq       <= 1'b0;
            yq       <= 1'b0;
        end else begin
            if (state == IDLE && d.start) begin
                xq <= d.xmsb;
                yq <= d.ymsb;
            end
            if (state == LOAD) begin
                step_q   <= d.y_zero ? '0 : CW'(N - 1);
                err_q    <= d.y_zero;
                padj_q   <= 1'b0;
                seladj_q <= 1'b0;
            end
            // step parks at 0 on the final digit so it never wraps
            if (state == ITER && step_q != '0) step_q <= step_q - 1'b1;
            if (state == ADJ) begin
                padj_q   <= d.padj_in;
                seladj_q <= d.seladj_in;
            end
        end
    end
    assign d.busy    = state == LOAD || state == ITER || state == ADJ;
    assign d.load_en = state == LOAD;
    assign d.iter_en = state == ITER;
    assign d.adj_en  = state == ADJ;
    assign d.done    = state == DONE;
    assign d.step    = step_q;
    assign d.padj    = padj_q;
    assign d.seladj  = seladj_q;
    assign d.err     = err_q;
    assign d.xmsb_q  = xq;
    assign d.ymsb_q  = yq;
endmodule

// File: tb/tb_intdiv_ctrl.sv
// tb_intdiv_ctrl: random stimulus against a cycles-since-acceptance timeline model of the divider sequencer.
module tb_intdiv_ctrl;
    localparam int N  = 16;
    localparam int CW = 5;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0, n_bad = 0;
    intdiv_ctrl_if #(.CW(CW)) b ();
    intdiv_ctrl #(.N(N), .CW(CW)) dut (.clk(clk), .rst(rst), .d(b));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // model: k counts cycles since acceptance; outputs follow the fixed latency schedule
    bit active, zero, e_x, e_y, e_padj, e_sel, e_err;
    int k, done_obs, done_exp, rst_hits;
    function automatic bit m_done();
        return active && k == (zero ? 2 : N + 3);
    endfunction
    function automatic bit m_iter();
        return active && !zero && k >= 2 && k <= N + 1;
    endfunction
    initial begin
        rst = 1'b1;
        {b.start, b.xmsb, b.ymsb, b.y_zero, b.padj_in, b.seladj_in} = '0;
        {active, zero, e_x, e_y, e_padj, e_sel, e_err} = '0;
        k = 0; done_obs = 0; done_exp = 0; rst_hits = 0;
        repeat (2) @(posedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            check("busy", b.busy, active && !m_done());
            check("load_en", b.load_en, active && k == 1);
            check("iter_en", b.iter_en, m_iter());
            check("step", b.step, m_iter() ? N + 1 - k : 0);
            check("adj_en", b.adj_en, active && !zero && k == N + 2);
            check("done", b.done, m_done());
            check("err", b.err, e_err);
            check("padj", b.padj, e_padj);
            check("seladj", b.seladj, e_sel);
            check("xmsb_q", b.xmsb_q, e_x);
            check("ymsb_q", b.ymsb_q, e_y);
            done_obs += int'(b.done);
            done_exp += int'(m_done());
            b.start     = (c >= 1000 && c < 1300) ? 1'b1 : ($urandom_range(0, 3) == 0);
            b.y_zero    = $urandom_range(0, 4) == 0;
            b.xmsb      = $urandom_range(0, 1) == 1;
            b.ymsb      = $urandom_range(0, 1) == 1;
            b.padj_in   = $urandom_range(0, 1) == 1;
            b.seladj_in = $urandom_range(0, 1) == 1;
            rst = 1'b0;
            if (c >= 1300 && m_iter() && N + 1 - k == 7 && rst_hits < 4) begin
                rst = 1'b1;
                rst_hits++;
            end else if (c >= 2000 && $urandom_range(0, 299) == 0) rst = 1'b1;
            @(posedge clk);
            if (rst) begin
                {active, zero, e_x, e_y, e_padj, e_sel, e_err} = '0;
                k = 0;
            end else if (!active) begin
                if (b.start) begin
                    active = 1'b1;
                    k = 1;
                    e_x = b.xmsb;
                    e_y = b.ymsb;
                end
            end else begin
                if (k == 1) begin
                    zero = b.y_zero;
                    e_err = b.y_zero;
                    e_padj = 1'b0;
                    e_sel = 1'b0;
                end
                if (!zero && k == N + 2) begin
                    e_padj = b.padj_in;
                    e_sel = b.seladj_in;
                end
                if (m_done()) begin
                    active = 1'b0;
                    zero = 1'b0;
                    k = 0;
                end else k++;
            end
        end
        @(negedge clk);
        check("done_count", done_obs, done_exp);
        check("mid_iter_resets", rst_hits, 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
